// File: rtl/mult_div_unit_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states, op decode helpers.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StZdiv
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return op inside {OpDiv, OpDivu};
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return op inside {OpMult, OpDiv};
    endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional negation of a {hi,lo} result pair: either as one 2*WIDTH value (products)
// or as two independent halves (remainder / quotient).
module mult_div_unit_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             pair_i,
    input  logic             neg_hi_i,
    input  logic             neg_lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] pair_neg;

    // Select negated or pass-through halves according to the sign flags.
    always_comb begin
        pair_neg = -{hi_i, lo_i};
        hi_o     = hi_i;
        lo_o     = lo_i;
        if (pair_i) begin
            // neg_lo_i carries the product sign when the pair is treated as one value
            if (neg_lo_i) begin
                {hi_o, lo_o} = pair_neg;
            end
        end else begin
            if (neg_hi_i) begin
                hi_o = -hi_i;
            end
            if (neg_lo_i) begin
                lo_o = -lo_i;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle integer multiply/divide unit owning the HI/LO pair. One result bit per cycle
// on operand magnitudes; signs are re-applied in a final FIX cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d, op_in;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_a_q, neg_a_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               sgn_in;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Operand magnitudes and one shift-add / restoring shift-subtract step.
    always_comb begin
        op_in  = mdu_op_e'(op_i);
        sgn_in = op_is_signed(op_in);
        abs_a  = (sgn_in && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
        abs_b  = (sgn_in && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

        // Multiplier sits in acc[W-1:0] and is consumed LSB first as the product shifts in.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder in acc[2W-1:W], dividend shifts out of the top of acc[W-1:0] as quotient
        // bits shift in at the bottom.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = rem_sh >= {1'b0, b_q};
        div_diff = rem_sh[WIDTH-1:0] - b_q;
        div_next = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end

    mult_div_unit_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .hi_i     (acc_q[2*WIDTH-1:WIDTH]),
        .lo_i     (acc_q[WIDTH-1:0]),
        .pair_i   (!op_is_div(op_q)),
        .neg_hi_i (op_is_div(op_q) ? neg_a_q : neg_res_q),
        .neg_lo_i (neg_res_q),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );

    // FSM next-state, counter and accumulator update.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_res_d  = neg_res_q;
        neg_a_d    = neg_a_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d       = op_in;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    busy_d     = 1'b1;
                    neg_res_d  = sgn_in && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                    neg_a_d    = sgn_in && src_a_i[WIDTH-1];
                    if (op_is_div(op_in)) begin
                        b_d     = abs_b;
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        state_d = (src_b_i == '0) ? StZdiv : StCalc;
                    end else begin
                        b_d     = abs_a;
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StZdiv: begin
                // hi/lo keep the previous result
                div_zero_d = 1'b1;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            op_q       <= OpMult;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_a_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_res_q  <= neg_res_d;
            neg_a_q    <= neg_a_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, model-checked random ops,
// and hand-written sequences for start-while-busy and mid-operation reset.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int           n_cmp = 0;
    int           n_fail = 0;
    exp_t         q_exp[$];
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;
    vec_t         vecs[13];

    always #5 clk = ~clk;

    mult_div_unit #(
        .WIDTH (W)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .op_i       (op),
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (div_zero),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model on native 64-bit arithmetic; a zero divisor keeps the old hi/lo.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        longint       sa, sb, q, r;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = last_hi;
        l  = last_lo;
        dz = 1'b0;
        case (o)
            2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            2'b10: begin
                if (b == '0) dz = 1'b1;
                else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
            end
            default: begin
                if (b == '0) dz = 1'b1;
                else begin h = a % b; l = a / b; end
            end
        endcase
    endtask

    // Issue one operation, push its expectation, wait (bounded) for done and compare.
    // ghost != 0 raises a stray start so that it is high at that edge after the accept.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                          input int ghost);
        exp_t e;
        int   n;
        int   pulses;
        bit   seen;
        e.hi  = ehi;
        e.lo  = elo;
        e.dz  = edz;
        e.lat = (o[1] && b == '0) ? 1 : W + 1;
        q_exp.push_back(e);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // operands must not be re-read after the accept edge
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        check("busy_after_accept", busy, 1);
        check("done_after_accept", done, 0);
        check("dz_cleared_on_start", div_zero, 0);
        n    = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (ghost != 0 && n == ghost - 1) begin
                start = 1'b1;
                op    = 2'b11;
                src_b = '0;
            end
            if (ghost != 0 && n == ghost) start = 1'b0;
            if (done) seen = 1;
            else check("busy_while_calc", busy, 1);
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done in %0d edges, expected one", n);
            void'(q_exp.pop_front());
        end else if (q_exp.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done, expected none queued");
        end else begin
            e = q_exp.pop_front();
            check("latency", n, e.lat);
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("div_zero", div_zero, e.dz);
            check("busy_in_done", busy, 0);
        end
        last_hi = ehi;
        last_lo = elo;
        if (ghost != 0) begin
            pulses = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (done || busy) pulses++;
            end
            check("ghost_start_ignored", pulses, 0);
        end
    endtask

    task automatic run_model_op(input logic [1:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int ghost);
        logic [W-1:0] h, l;
        logic         dz;
        model(o, a, b, h, l, dz);
        run_op(o, a, b, h, l, dz, ghost);
    endtask

    initial begin
        int           n;
        int           pulses;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
        vecs[7]  = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b1};
        vecs[8]  = '{2'b01, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0};
        vecs[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
        vecs[11] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1};
        vecs[12] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dz", div_zero, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);

        // Back-to-back: each start is raised in the done cycle of the previous op.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 0);
        end

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? '0 :
                 ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            run_model_op(ro, ra, rb, 0);
        end

        // Stray start at edge 10 of a MULT must be ignored.
        run_model_op(2'b00, 32'h0001_2345, 32'hFFFF_FFFD, 10);

        // Reset at edge 10 of a MULT aborts it.
        op    = 2'b00;
        src_a = 32'h0000_1234;
        src_b = 32'h0000_5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 9) begin
            @(posedge clk);
            #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        last_hi = '0;
        last_lo = '0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("abort_no_done", pulses, 0);

        run_model_op(2'b11, 32'h0000_03E8, 32'h0000_0000, 0);
        run_model_op(2'b10, 32'hFFFF_FC18, 32'h0000_0021, 0);

        check("scoreboard_empty", q_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
